// File: rtl/data_sram_req_ctrl.sv
// data_sram_req_ctrl: MEM-stage data-SRAM request initiator.
// Accepts one load/store from EX and builds byte strobes and lane-replicated
// write data. It runs the addr_ok/data_ok handshake and stalls the pipeline
// while a transaction is outstanding. The raw read word is buffered for the
// MEM/WB load-extension logic.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   req_valid/we/size/addr/wdata   memory op from EX
//   pipe_stall                     MEM->WB advance blocked
//   data_sram_*                    data-SRAM bus (req/wr/size/addr/wstrb/wdata out;
//                                  addr_ok/data_ok/rdata in)
//   stallreq_for_mem               stall request to pipeline controller
//   resp_valid, resp_rdata         buffered response (rdata is 0 for stores)
//   addr_err                       misaligned access flag
//
// Optional feature: define MISALIGN_EXC_EN to trap misaligned half/word
// accesses. The trapped access never reaches the bus and completes with
// addr_err. Without the macro, low address bits are forced to alignment.
module data_sram_req_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        pipe_stall,
  output logic        data_sram_req,
  output logic        data_sram_wr,
  output logic [1:0]  data_sram_size,
  output logic [31:0] data_sram_addr,
  output logic [3:0]  data_sram_wstrb,
  output logic [31:0] data_sram_wdata,
  input  logic        data_sram_addr_ok,
  input  logic        data_sram_data_ok,
  input  logic [31:0] data_sram_rdata,
  output logic        stallreq_for_mem,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        addr_err
);

  typedef enum logic [1:0] {StIdle, StAddr, StData, StDone} state_e;

  state_e      state_q, state_d;
  logic        accept;
  logic        is_half, is_word, misalign;
  logic [31:0] lane_addr, lane_wdata;
  logic [3:0]  lane_wstrb;

  logic        wr_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [3:0]  wstrb_q;

  assign is_half = (req_size == 2'b01);
  assign is_word = req_size[1];  // 11 behaves as word

`ifdef MISALIGN_EXC_EN
  assign misalign = (is_half & req_addr[0]) | (is_word & (|req_addr[1:0]));
`else
  assign misalign = 1'b0;
`endif

  // Lane generation from the incoming request; registered on accept.
  always_comb begin
    lane_addr  = req_addr;
    lane_wdata = req_wdata;
    lane_wstrb = 4'b0000;
    if (is_word) begin
      lane_wstrb = 4'b1111;
    end else if (is_half) begin
      lane_wstrb = req_addr[1] ? 4'b1100 : 4'b0011;
      lane_wdata = {2{req_wdata[15:0]}};
    end else begin
      lane_wstrb = 4'b0001 << req_addr[1:0];
      lane_wdata = {4{req_wdata[7:0]}};
    end
    if (!req_we) begin
      lane_wstrb = 4'b0000;
    end
`ifndef MISALIGN_EXC_EN
    if (is_word) begin
      lane_addr[1:0] = 2'b00;
    end else if (is_half) begin
      lane_addr[0] = 1'b0;
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      StIdle: begin
        if (req_valid) begin
          accept  = 1'b1;
          state_d = misalign ? StDone : StAddr;
        end
      end
      StAddr: begin
        if (data_sram_addr_ok) state_d = StData;
      end
      StData: begin
        if (data_sram_data_ok) state_d = StDone;
      end
      StDone: begin
        if (!pipe_stall) begin
          if (req_valid) begin
            accept  = 1'b1;
            state_d = misalign ? StDone : StAddr;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      wr_q    <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= '0;
      wstrb_q <= 4'b0000;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        wr_q    <= req_we;
        size_q  <= req_size;
        addr_q  <= lane_addr;
        wstrb_q <= lane_wstrb;
        wdata_q <= lane_wdata;
      end
      if (accept && misalign) begin
        rdata_q <= '0;
      end else if (state_q == StData && data_sram_data_ok) begin
        rdata_q <= wr_q ? 32'h0 : data_sram_rdata;
      end
    end
  end

`ifdef MISALIGN_EXC_EN
  logic err_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= misalign;
    end
  end
  assign addr_err = err_q;
`else
  assign addr_err = 1'b0;
`endif

  assign data_sram_req   = (state_q == StAddr);
  assign data_sram_wr    = wr_q;
  assign data_sram_size  = size_q;
  assign data_sram_addr  = addr_q;
  assign data_sram_wstrb = wstrb_q;
  assign data_sram_wdata = wdata_q;

  // EX is allowed to advance in DONE, even when it hands over a new request.
  assign stallreq_for_mem = ((state_q == StIdle) && accept && !misalign) ||
                            (state_q == StAddr) || (state_q == StData);

  assign resp_valid = (state_q == StDone);
  assign resp_rdata = rdata_q;

endmodule

// File: tb/tb_data_sram_req_ctrl.sv
module tb_data_sram_req_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_we, pipe_stall;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        data_sram_req, data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [31:0] data_sram_addr, data_sram_wdata, data_sram_rdata;
  logic [3:0]  data_sram_wstrb;
  logic        data_sram_addr_ok, data_sram_data_ok;
  logic        stallreq_for_mem, resp_valid, addr_err;
  logic [31:0] resp_rdata;

  int n_chk  = 0;
  int n_pass = 0;

  // Transaction currently owned by the DUT.
  logic        cur_we;
  logic [1:0]  cur_size;
  logic [31:0] cur_addr, cur_wdata;

`ifdef MISALIGN_EXC_EN
  localparam bit MisEn = 1'b1;
`else
  localparam bit MisEn = 1'b0;
`endif

  always #5 clk = ~clk;

  data_sram_req_ctrl dut (
    .clk               (clk),
    .rst               (rst),
    .req_valid         (req_valid),
    .req_we            (req_we),
    .req_size          (req_size),
    .req_addr          (req_addr),
    .req_wdata         (req_wdata),
    .pipe_stall        (pipe_stall),
    .data_sram_req     (data_sram_req),
    .data_sram_wr      (data_sram_wr),
    .data_sram_size    (data_sram_size),
    .data_sram_addr    (data_sram_addr),
    .data_sram_wstrb   (data_sram_wstrb),
    .data_sram_wdata   (data_sram_wdata),
    .data_sram_addr_ok (data_sram_addr_ok),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata),
    .stallreq_for_mem  (stallreq_for_mem),
    .resp_valid        (resp_valid),
    .resp_rdata        (resp_rdata),
    .addr_err          (addr_err)
  );

  // Reference model: plain arithmetic on the transaction fields.
  function automatic bit is_mis(input logic [1:0] size, input logic [31:0] addr);
    if (!MisEn) return 1'b0;
    if (size == 2'd1) return (addr % 2) != 0;
    if (size >= 2'd2) return (addr % 4) != 0;
    return 1'b0;
  endfunction

  function automatic logic [31:0] exp_addr(input logic [1:0] size, input logic [31:0] addr);
    if (MisEn || size == 2'd0) return addr;
    if (size == 2'd1) return addr - (addr % 2);
    return addr - (addr % 4);
  endfunction

  function automatic logic [3:0] exp_wstrb(input logic we, input logic [1:0] size,
                                           input logic [31:0] addr);
    if (!we) return 4'd0;
    if (size == 2'd0) return 4'(2 ** (addr % 4));
    if (size == 2'd1) return ((addr % 4) >= 2) ? 4'd12 : 4'd3;
    return 4'd15;
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [1:0] size, input logic [31:0] wd);
    if (size == 2'd0) return {24'd0, wd[7:0]} * 32'h0101_0101;
    if (size == 2'd1) return {16'd0, wd[15:0]} * 32'h0001_0001;
    return wd;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_bus(input string ph);
    chk({ph, "_wr"},    32'(data_sram_wr), 32'(cur_we));
    chk({ph, "_size"},  32'(data_sram_size), 32'(cur_size));
    chk({ph, "_addr"},  data_sram_addr, exp_addr(cur_size, cur_addr));
    chk({ph, "_wstrb"}, 32'(data_sram_wstrb), 32'(exp_wstrb(cur_we, cur_size, cur_addr)));
    chk({ph, "_wdata"}, data_sram_wdata, exp_wdata(cur_size, cur_wdata));
  endtask

  task automatic check_all_zero(input string ph);
    chk({ph, "_req"},   32'(data_sram_req), 0);
    chk({ph, "_wr"},    32'(data_sram_wr), 0);
    chk({ph, "_size"},  32'(data_sram_size), 0);
    chk({ph, "_addr"},  data_sram_addr, 0);
    chk({ph, "_wstrb"}, 32'(data_sram_wstrb), 0);
    chk({ph, "_wdata"}, data_sram_wdata, 0);
    chk({ph, "_stall"}, 32'(stallreq_for_mem), 0);
    chk({ph, "_rv"},    32'(resp_valid), 0);
    chk({ph, "_rdata"}, resp_rdata, 0);
    chk({ph, "_err"},   32'(addr_err), 0);
  endtask

  task automatic rand_req_fields();
    req_we    = 1'($urandom);
    req_size  = 2'($urandom);
    req_addr  = $urandom;
    req_wdata = $urandom;
  endtask

  // Present cur_* from IDLE.
  task automatic do_accept();
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = cur_we;
    req_size  = cur_size;
    req_addr  = cur_addr;
    req_wdata = cur_wdata;
    pipe_stall        = 1'($urandom);
    data_sram_addr_ok = 1'b0;
    data_sram_data_ok = 1'b0;
    #1;
    chk("acc_stall", 32'(stallreq_for_mem), 32'(!is_mis(cur_size, cur_addr)));
    chk("acc_req",   32'(data_sram_req), 0);
    chk("acc_rv",    32'(resp_valid), 0);
  endtask

  // Cycle-exact walk through ADDR/DATA/DONE for the accepted cur_* request.
  // With chain set, the final DONE cycle hands over the next request.
  task automatic do_body(input logic [31:0] rd, input int a_dly, input int d_dly,
                         input int stall_n, input bit chain, input logic n_we,
                         input logic [1:0] n_size, input logic [31:0] n_addr,
                         input logic [31:0] n_wdata);
    bit          mis    = is_mis(cur_size, cur_addr);
    logic [31:0] exp_rd = (mis || cur_we) ? 32'h0 : rd;
    if (!mis) begin
      for (int k = 0; k <= a_dly; k++) begin
        @(negedge clk);
        req_valid         = 1'($urandom);
        rand_req_fields();
        pipe_stall        = 1'($urandom);
        data_sram_addr_ok = (k == a_dly);
        data_sram_data_ok = (k < a_dly) ? 1'($urandom) : 1'b0;
        data_sram_rdata   = $urandom;
        #1;
        chk("addr_req",   32'(data_sram_req), 1);
        chk("addr_stall", 32'(stallreq_for_mem), 1);
        chk("addr_rv",    32'(resp_valid), 0);
        check_bus("addr");
      end
      for (int k = 0; k <= d_dly; k++) begin
        @(negedge clk);
        req_valid         = 1'($urandom);
        rand_req_fields();
        data_sram_addr_ok = 1'b0;
        data_sram_data_ok = (k == d_dly);
        data_sram_rdata   = (k == d_dly) ? rd : $urandom;
        #1;
        chk("data_req",   32'(data_sram_req), 0);
        chk("data_stall", 32'(stallreq_for_mem), 1);
        chk("data_rv",    32'(resp_valid), 0);
      end
    end
    for (int k = 0; k <= stall_n; k++) begin
      @(negedge clk);
      data_sram_addr_ok = 1'b0;
      data_sram_data_ok = 1'($urandom);
      data_sram_rdata   = $urandom;
      pipe_stall        = (k < stall_n);
      if (k < stall_n) begin
        req_valid = 1'($urandom);
        rand_req_fields();
      end else if (chain) begin
        req_valid = 1'b1;
        req_we    = n_we;
        req_size  = n_size;
        req_addr  = n_addr;
        req_wdata = n_wdata;
      end else begin
        req_valid = 1'b0;
      end
      #1;
      chk("done_rv",    32'(resp_valid), 1);
      chk("done_rdata", resp_rdata, exp_rd);
      chk("done_stall", 32'(stallreq_for_mem), 0);
      chk("done_req",   32'(data_sram_req), 0);
      chk("done_err",   32'(addr_err), 32'(mis));
      check_bus("done");
    end
    if (chain) begin
      cur_we    = n_we;
      cur_size  = n_size;
      cur_addr  = n_addr;
      cur_wdata = n_wdata;
    end
  endtask

  initial begin
    bit chained;
    bit ch;
    rst               = 1'b1;
    req_valid         = 1'b0;
    req_we            = 1'b0;
    req_size          = 2'd0;
    req_addr          = '0;
    req_wdata         = '0;
    pipe_stall        = 1'b0;
    data_sram_addr_ok = 1'b0;
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = '0;
    repeat (2) @(negedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // sb at 0x1003: top byte lane, replicated data.
    cur_we = 1'b1; cur_size = 2'd0; cur_addr = 32'h0000_1003; cur_wdata = 32'h0000_00AB;
    do_accept();
    do_body(32'h0, 0, 0, 0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);

    // lw at 0x2000 with addr_ok after 3 waits, data_ok one DATA cycle late.
    cur_we = 1'b0; cur_size = 2'd2; cur_addr = 32'h0000_2000; cur_wdata = $urandom;
    do_accept();
    do_body(32'hDEAD_BEEF, 3, 1, 0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);

    // Load completing under a 3-cycle pipe_stall.
    cur_we = 1'b0; cur_size = 2'd1; cur_addr = 32'h0000_2006; cur_wdata = $urandom;
    do_accept();
    do_body($urandom, 0, 0, 3, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);

    // Reset in DATA, then a late data_ok.
    cur_we = 1'b0; cur_size = 2'd2; cur_addr = 32'h0000_4000; cur_wdata = $urandom;
    do_accept();
    @(negedge clk);
    req_valid = 1'b0;
    data_sram_addr_ok = 1'b1;
    #1;
    chk("rstx_req", 32'(data_sram_req), 1);
    @(negedge clk);
    data_sram_addr_ok = 1'b0;
    rst = 1'b1;
    #1;
    chk("rstx_stall", 32'(stallreq_for_mem), 1);
    @(negedge clk);
    rst = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h1234_5678;
    #1;
    check_all_zero("rstx");
    @(negedge clk);
    data_sram_data_ok = 1'b0;
    #1;
    chk("rstx_late_rv",    32'(resp_valid), 0);
    chk("rstx_late_rdata", resp_rdata, 0);
    chk("rstx_late_stall", 32'(stallreq_for_mem), 0);

    // sh at 0x3001: trapped with the macro, aligned down without it.
    cur_we = 1'b1; cur_size = 2'd1; cur_addr = 32'h0000_3001; cur_wdata = 32'h0000_5A5A;
    do_accept();
    do_body(32'h0, 0, 0, 0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);

    // Back-to-back sw at 0x10 then 0x14.
    cur_we = 1'b1; cur_size = 2'd2; cur_addr = 32'h0000_0010; cur_wdata = 32'h1111_2222;
    do_accept();
    do_body(32'h0, 0, 0, 0, 1'b1, 1'b1, 2'd2, 32'h0000_0014, 32'h3333_4444);
    do_body(32'h0, 0, 0, 0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);

    // Randomised transactions, sometimes chained from DONE.
    chained = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (!chained) begin
        cur_we    = 1'($urandom);
        cur_size  = 2'($urandom);
        cur_addr  = $urandom;
        cur_wdata = $urandom;
        do_accept();
      end
      ch = (i < 59) ? 1'($urandom) : 1'b0;
      do_body($urandom, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 2)), ch, 1'($urandom), 2'($urandom), $urandom,
              $urandom);
      chained = ch;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
